// File: rtl/data_bus_confreg_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_bus_confreg_if
//  Description : CPU data-SRAM port and external RAM port seen by the confreg
//                bridge. master = CPU/RAM side, slave = the bridge.
//  Revision    : 1.0  initial release
// ============================================================================
interface data_bus_confreg_if;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport master (
        output cpu_en, cpu_wen, cpu_addr, cpu_wdata, ram_rdata,
        input  cpu_rdata, ram_en, ram_wen, ram_addr, ram_wdata
    );

    modport slave (
        input  cpu_en, cpu_wen, cpu_addr, cpu_wdata, ram_rdata,
        output cpu_rdata, ram_en, ram_wen, ram_addr, ram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/data_bus_confreg.sv
`default_nettype none
// ============================================================================
//  Module      : data_bus_confreg
//  Description : Splits CPU data accesses between external sync RAM and an
//                on-chip register file, with a fixed 1-cycle read latency.
//  Revision    : 1.0  initial release
// ============================================================================
module data_bus_confreg #(
    parameter logic [15:0] CONF_BASE_HI = 16'hbfaf,
    parameter int          LED_W        = 16,
    parameter int          SW_W         = 8
) (
    input  logic              clk,
    input  logic              resetn,
    data_bus_confreg_if.slave bus,
    output logic [LED_W-1:0]  led,
    input  logic [SW_W-1:0]   switch
);

    localparam logic [13:0] c_off_timer  = 14'h3800;  // 0xE000 >> 2
    localparam logic [13:0] c_off_led    = 14'h3C00;  // 0xF000 >> 2
    localparam logic [13:0] c_off_num    = 14'h3C04;  // 0xF010 >> 2
    localparam logic [13:0] c_off_switch = 14'h3C0C;  // 0xF030 >> 2

    logic [31:0]      r_cr [8];
    logic [31:0]      r_num;
    logic [31:0]      r_timer;
    logic [LED_W-1:0] r_led;
    logic [SW_W-1:0]  r_sw_s1;
    logic [SW_W-1:0]  r_sw_s2;
    logic             r_sel;
    logic [31:0]      r_conf_rdata;

    logic        w_conf_hit;
    logic        w_wr;
    logic [13:0] w_word;
    logic [2:0]  w_cr_idx;
    logic        w_cr_hit;
    logic [31:0] w_rd_val;
    logic [31:0] w_led_merged;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++)
            if (lanes[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
        return res;
    endfunction

    assign w_conf_hit = (bus.cpu_addr[31:16] == CONF_BASE_HI);
    assign w_wr       = bus.cpu_en && w_conf_hit && (bus.cpu_wen != 4'h0);
    assign w_word     = bus.cpu_addr[15:2];
    assign w_cr_idx   = bus.cpu_addr[4:2];
    assign w_cr_hit   = (bus.cpu_addr[15:5] == 11'h000);

    assign bus.ram_en    = bus.cpu_en && !w_conf_hit;
    assign bus.ram_wen   = w_conf_hit ? 4'h0 : bus.cpu_wen;
    assign bus.ram_addr  = bus.cpu_addr;
    assign bus.ram_wdata = bus.cpu_wdata;
    assign bus.cpu_rdata = r_sel ? r_conf_rdata : bus.ram_rdata;

    assign led          = r_led;
    assign w_led_merged = f_merge(32'(r_led), bus.cpu_wdata, bus.cpu_wen & 4'b0011);

    // TIMER reads capture the count it will hold when the data is returned,
    // so a read right after a write sees the written value plus one.
    always_comb begin
        w_rd_val = 32'h0;
        if (w_cr_hit)                  w_rd_val = r_cr[w_cr_idx];
        else if (w_word == c_off_timer)  w_rd_val = r_timer + 32'd1;
        else if (w_word == c_off_led)    w_rd_val = 32'(r_led);
        else if (w_word == c_off_num)    w_rd_val = r_num;
        else if (w_word == c_off_switch) w_rd_val = 32'(r_sw_s2);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) r_cr[i] <= 32'h0;
            r_num        <= 32'h0;
            r_timer      <= 32'h0;
            r_led        <= '0;
            r_sw_s1      <= '0;
            r_sw_s2      <= '0;
            r_sel        <= 1'b0;
            r_conf_rdata <= 32'h0;
        end else begin
            r_sw_s1 <= switch;
            r_sw_s2 <= r_sw_s1;

            if (w_wr && w_word == c_off_timer)
                r_timer <= f_merge(r_timer, bus.cpu_wdata, bus.cpu_wen);
            else
                r_timer <= r_timer + 32'd1;

            if (w_wr) begin
                if (w_cr_hit)
                    r_cr[w_cr_idx] <= f_merge(r_cr[w_cr_idx], bus.cpu_wdata, bus.cpu_wen);
                if (w_word == c_off_led)
                    r_led <= w_led_merged[LED_W-1:0];
                if (w_word == c_off_num)
                    r_num <= f_merge(r_num, bus.cpu_wdata, bus.cpu_wen);
            end

            if (bus.cpu_en) begin
                r_sel <= w_conf_hit;
                if (w_conf_hit) r_conf_rdata <= w_rd_val;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/data_bus_confreg.md
Name: data_bus_confreg

Overview:
- Sits directly downstream of the pipelined CPU's data SRAM port (EXE stage issues, MEM stage consumes read data one cycle later).
- Decodes each access to either the external data RAM (pass-through) or an on-chip config/peripheral register file: CR0–CR7, LED, NUM, SWITCH, TIMER.
- Returns read data with the same fixed 1-cycle latency as a synchronous SRAM, so the CPU needs no stall logic.

Parameters:
- CONF_BASE_HI, 16'hbfaf, addr[31:16] value selecting the confreg region.
- LED_W, 16, width of LED register/output.
- SW_W, 8, width of switch input.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous reset, active-low. One clock; all state resets on a rising clk edge with resetn=0.
- cpu_en  in  1  CPU data access enable.
- cpu_wen  in  4  byte write enables; 0 means read.
- cpu_addr  in  32  byte address; bits [1:0] ignored.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data, valid the cycle after the request.
- ram_en  out  1  RAM enable.
- ram_wen  out  4  RAM byte write enables.
- ram_addr  out  32  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  sync RAM read data, valid 1 cycle after ram_en.
- led  out  LED_W  LED register value.
- switch  in  SW_W  asynchronous switch inputs.

Behaviour:
- Decode: conf_hit = cpu_addr[31:16]==CONF_BASE_HI.
- Register offsets (addr[15:0]): CR0–CR7 at 0x0000–0x001C (rw); TIMER 0xE000 (rw); LED 0xF000 (rw, low LED_W bits); NUM 0xF010 (rw, 32b); SWITCH 0xF030 (ro, zero-extended).
- Unmapped offsets in the region: read 0, writes ignored.
- RAM path (combinational):
  - ram_en = cpu_en & ~conf_hit.
  - ram_wen = conf_hit ? 0 : cpu_wen.
  - ram_addr/ram_wdata = cpu_addr/cpu_wdata.
- Writes: when cpu_en & conf_hit & cpu_wen!=0, update each written byte lane of the target register at the clk edge; unwritten lanes keep their value. LED honours lanes 0–1 only.
- TIMER:
  - Free-running 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF→0.
  - A write cycle loads the byte-merged value instead of incrementing.
- SWITCH: two-flop synchroniser. A read returns the value sampled through the second flop.
- Read pipeline, on each edge with cpu_en=1:
  - sel_q <= conf_hit.
  - If conf_hit, conf_rdata_q <= current value of the addressed register (pre-write value if the same cycle writes).
  - With cpu_en=0, sel_q and conf_rdata_q hold.
- cpu_rdata = sel_q ? conf_rdata_q : ram_rdata (combinational). Write cycles also update sel_q; read data returned after a write is don't-care.
- Reset values (all 0):
  - CR0–7, NUM, LED, TIMER, both sync flops, sel_q, conf_rdata_q.
  - led=0; cpu_rdata=ram_rdata after reset (sel_q=0).
- Reset mid-operation: an access in the reset cycle has no effect on confreg state. RAM pass-through stays purely combinational.
- Back-to-back: a write at cycle N followed by a read of the same register at N+1 returns the written value at N+2. TIMER returns written value +1 in that case.
- No internal backpressure; every accepted access completes in exactly 1 cycle.

Test Plan:
- RAM pass-through: write addr 0x00001000, wen=4'hf, data 0xDEADBEEF, then read same address. Require ram_en=1, ram_wen=4'hf on write; cpu_rdata=ram_rdata=0xDEADBEEF one cycle after the read; confreg state unchanged.
- CR byte writes: write CR3 (0xbfaf000c) 0x11223344 with wen=4'hf, then 0xAA with wen=4'b0001. Read → 0x112233AA; ram_en=0 and ram_wen=0 throughout.
- TIMER: after reset release, read TIMER at cycle 10 → known count. Write 0xFFFFFFFE, read next cycle → 0xFFFFFFFF. Read on the following cycle → 0x00000000 (wrap).
- LED/SWITCH: write LED 0x0000A5A5 → led=16'hA5A5 next edge. Change switch to 8'h3C → SWITCH read reflects 0x3C no earlier than 2 edges later.
- Unmapped/readback mux: read 0xbfaf0100 → 0. Interleave RAM read and confreg read on consecutive cycles → each cpu_rdata matches its own source.
- Reset mid-run: set NUM=0x12345678 and let TIMER run, assert resetn=0 for one cycle with a concurrent CR0 write. Require NUM=TIMER=CR0=0, led=0, sel_q=0.
